load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Execute-to-memory stage sitting directly downstream of the ALU.
- Consumes ALUResult as the effective address for RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Runs a ready-based handshake with data memory, stalls the pipeline while an access is in flight, and returns a sign- or zero-extended ReadData.
- Flags misaligned accesses and bus timeouts.

Parameters:
- DATA_WIDTH, 32, data and address width (byte lanes fixed at DATA_WIDTH/8 = 4).
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ waiting for mem_ready before abort.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- MemRead  input  1  load request; held stable by the pipeline while Stall=1.
- MemWrite  input  1  store request; held stable while Stall=1.
- Funct3  input  3  RV32I funct3 of the load/store.
- ALUResult  input  DATA_WIDTH  effective byte address from the ALU.
- WriteData  input  DATA_WIDTH  rs2 store data (low bytes used for SB/SH).
- mem_req  output  1  memory request valid (registered).
- mem_we  output  1  1 = write, 0 = read (registered).
- mem_addr  output  DATA_WIDTH  word-aligned address, ALUResult with bits [1:0] cleared (registered).
- mem_wdata  output  DATA_WIDTH  store data replicated into the addressed lanes (registered).
- mem_wstrb  output  4  byte-lane write strobes; 0 for reads (registered).
- mem_ready  input  1  memory accepted/completed the request this cycle.
- mem_rdata  input  DATA_WIDTH  read word; valid when mem_ready=1.
- ReadData  output  DATA_WIDTH  extended load result (registered, holds until next load completes).
- Stall  output  1  combinational; freeze upstream pipeline.
- Done  output  1  one-cycle pulse; access complete.
- Misaligned  output  1  one-cycle pulse; access rejected for misalignment.
- BusError  output  1  one-cycle pulse; timeout abort.

Behaviour:
- Reset (reset=0 at a rising edge): state IDLE. mem_req, mem_we, mem_wstrb, Done, Misaligned and BusError are 0. mem_addr, mem_wdata and ReadData are 0. Timeout counter is 0.
- Reset is honoured in any state: an in-flight access is abandoned, mem_req=0 from the next cycle, and no Done/BusError is produced.
- Access width from Funct3[1:0]: 00 byte, 01 half, 10 word. 11 is treated as word. Funct3[2]=1 selects zero-extension for loads and is ignored for stores.
- Misalignment: half with addr[0]=1; word with addr[1:0]!=0. Byte accesses are never misaligned.
- MemRead and MemWrite both high: treated as a load; the write is ignored.
- Three-state FSM:
  - IDLE:
    - No request → stay in IDLE; Stall=0.
    - Misaligned request → Misaligned=1 next cycle; no memory access; stay in IDLE; Stall=0.
    - Aligned request → Stall=1. Register mem_req=1, mem_we, mem_addr, mem_wdata and mem_wstrb; go to REQ; clear the counter.
  - REQ:
    - Stall=1; mem_req held at 1 with all memory outputs stable.
    - mem_ready=1 → capture the extended load data into ReadData (loads only), mem_req=0, go to DONE.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ready: mem_req=0, BusError=1 next cycle, go to IDLE; ReadData is unchanged.
  - DONE:
    - Done=1, Stall=0; ReadData valid. Go to IDLE unconditionally.
    - The pipeline advances on this edge; IDLE samples the next instruction.
- Minimum latency (mem_ready already high in the first REQ cycle): request seen in IDLE at cycle 0, REQ at cycle 1, DONE at cycle 2. Stall is high for exactly 2 cycles.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0]; byte replicated ×4.
  - SH: wstrb = 0011 or 1100; half replicated ×2.
  - SW: wstrb = 1111.
- Load extraction:
  - Byte = mem_rdata[8*addr[1:0] +: 8].
  - Half = mem_rdata[16*addr[1] +: 16].
  - Sign-extend unless Funct3[2]=1.
- mem_ready while not in REQ: ignored.

Test Plan:
- Word store/load: SW addr 0x100, data 0xDEADBEEF, ready immediate → mem_addr=0x100, wstrb=1111, Stall high 2 cycles, Done at cycle 2. Then LW 0x100 with rdata 0xDEADBEEF → ReadData=0xDEADBEEF.
- Byte loads: rdata 0x80FF7F01. LB 0x203 → 0xFFFFFF80; LBU 0x203 → 0x00000080; LB 0x201 → 0x0000007F.
- Half store: SH addr 0x102, WriteData 0x1234ABCD → mem_addr=0x100, wstrb=1100, wdata=0xABCDABCD. LH 0x102 with rdata 0xABCD0000 → ReadData=0xFFFFABCD.
- Misaligned: LW at 0x101 and LH at 0x103 → Misaligned pulse 1 cycle, mem_req never asserted, Stall=0.
- Wait states and timeout: ready after 3 wait cycles → Done 5 cycles after acceptance. Ready never asserted → BusError after 16 REQ cycles, mem_req drops, back to IDLE.
- Reset mid-access: reset=0 in the second REQ cycle → next cycle mem_req=0, Stall=0, no Done/BusError, ReadData=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Execute-to-memory load/store stage: RV32I access sizing, lane steering, ready handshake,
// pipeline stall, load extension, misalignment rejection and bus timeout.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  Done,
    output logic                  Misaligned,
    output logic                  BusError
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_count;
    logic [1:0]      r_size;
    logic [1:0]      r_off;
    logic            r_uns;
    logic            r_load;

    logic            w_misaligned, w_accept, w_bad, w_complete, w_timeout;
    logic [3:0]      w_wstrb;
    logic [DATA_WIDTH-1:0] w_wdata, w_load_ext;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    always_comb begin
        w_misaligned = 1'b0;
        w_wstrb      = 4'b1111;
        w_wdata      = WriteData;
        case (Funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << ALUResult[1:0];
                w_wdata = {NB{WriteData[7:0]}};
            end
            2'b01: begin
                w_misaligned = ALUResult[0];
                w_wstrb      = ALUResult[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {(NB/2){WriteData[15:0]}};
            end
            default: w_misaligned = (ALUResult[1:0] != 2'b00);
        endcase
    end

    // Lane selection uses the offset/size captured at acceptance, not the live inputs.
    always_comb begin
        w_byte     = mem_rdata[{r_off, 3'b000} +: 8];
        w_half     = mem_rdata[{r_off[1], 4'b0000} +: 16];
        w_load_ext = mem_rdata;
        case (r_size)
            2'b00:   w_load_ext = r_uns ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                        : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = r_uns ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                        : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        Stall      = 1'b0;
        Done       = 1'b0;
        w_accept   = 1'b0;
        w_bad      = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemRead | MemWrite) begin
                    if (w_misaligned) begin
                        w_bad = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        Stall    = 1'b1;
                        w_next   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                Stall = 1'b1;
                if (mem_ready) begin
                    w_complete = 1'b1;
                    w_next     = S_DONE;
                end else if (r_count == TMAX) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_DONE: begin
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            ReadData   <= '0;
            Misaligned <= 1'b0;
            BusError   <= 1'b0;
            r_count    <= '0;
            r_size     <= '0;
            r_off      <= '0;
            r_uns      <= 1'b0;
            r_load     <= 1'b0;
        end else begin
            Misaligned <= w_bad;
            BusError   <= w_timeout;
            if (w_accept) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWrite & ~MemRead;
                mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                mem_wdata <= w_wdata;
                mem_wstrb <= MemRead ? 4'b0000 : w_wstrb;
                r_count   <= '0;
                r_size    <= Funct3[1:0];
                r_off     <= ALUResult[1:0];
                r_uns     <= Funct3[2];
                r_load    <= MemRead;
            end else if (r_state == S_REQ) begin
                if (w_complete || w_timeout) mem_req <= 1'b0;
                if (w_complete && r_load)    ReadData <= w_load_ext;
                if (!mem_ready && !w_timeout) r_count <= r_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-access expectations queued at issue, checked on completion.
module tb_load_store_unit;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemRead, MemWrite;
    logic [2:0]    Funct3;
    logic [DW-1:0] ALUResult, WriteData;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata, ReadData;
    logic          Stall, Done, Misaligned, BusError;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .ReadData(ReadData), .Stall(Stall),
        .Done(Done), .Misaligned(Misaligned), .BusError(BusError)
    );

    typedef struct {
        logic [2:0]  evt;     // {Done, Misaligned, BusError}
        int          lat;
        int          stalls;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          op_id  = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL op%0d %s: observed 0x%08h expected 0x%08h", op_id, tag, obs, exp);
        end
    endtask

    function automatic logic model_misal(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00)      return 1'b0;
        else if (f3[1:0] == 2'b01) return a[0];
        else                       return a[1] | a[0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        if (f3[1:0] == 2'b00) begin
            sh = rd >> (a[1:0] * 8);
            return f3[2] ? (sh & 32'h0000_00FF) : 32'($signed(sh[7:0]));
        end else if (f3[1:0] == 2'b01) begin
            sh = a[1] ? (rd >> 16) : rd;
            return f3[2] ? (sh & 32'h0000_FFFF) : 32'($signed(sh[15:0]));
        end
        return rd;
    endfunction

    // waits < 0 means memory never answers.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waits,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata);
        exp_t e, got;
        logic mis, prev_stall, seen_req, ended;
        int   stalls;
        op_id++;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr;
        WriteData = wd; mem_rdata = rdat; mem_ready = 1'b0;
        mis = model_misal(f3, addr);
        e.evt    = mis ? 3'b010 : (waits < 0 ? 3'b001 : 3'b100);
        e.lat    = mis ? 1 : (waits < 0 ? TO + 1 : waits + 2);
        e.stalls = mis ? 0 : e.lat;
        e.rdata  = (rd && e.evt == 3'b100) ? model_load(f3, addr, rdat) : last_rd;
        last_rd  = e.rdata;
        sb.push_back(e);
        #1;
        stalls = 0; seen_req = 1'b0; ended = 1'b0;
        prev_stall = Stall;
        stalls += int'(Stall);
        check("stall_c0", {31'b0, Stall}, {31'b0, ~mis});
        for (int cyc = 1; cyc <= 40 && !ended; cyc++) begin
            @(posedge clk); #1;
            if (!prev_stall) begin MemRead = 1'b0; MemWrite = 1'b0; end
            mem_ready = (waits >= 0) && (cyc - 1 >= waits);
            #1;
            seen_req |= mem_req;
            if (cyc == 1 && !mis) begin
                check("req", {31'b0, mem_req}, 32'd1);
                check("addr", mem_addr, {addr[31:2], 2'b00});
                check("we", {31'b0, mem_we}, {31'b0, wr & ~rd});
                check("wstrb", {28'b0, mem_wstrb}, rd ? 32'd0 : {28'b0, e_strb});
                if (!rd) check("wdata", mem_wdata, e_wdata);
            end
            if (Done || Misaligned || BusError) begin
                ended = 1'b1;
                MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
                #1;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(sb.size()), 32'd1);
                end else begin
                    got = sb.pop_front();
                    check("event", {29'b0, Done, Misaligned, BusError}, {29'b0, got.evt});
                    check("latency", 32'(cyc), 32'(got.lat));
                    check("stall_cycles", 32'(stalls), 32'(got.stalls));
                    check("readdata", ReadData, got.rdata);
                end
                check("stall_end", {31'b0, Stall}, 32'd0);
                check("req_end", {31'b0, mem_req}, 32'd0);
                if (mis) check("no_req", {31'b0, seen_req}, 32'd0);
            end else begin
                stalls += int'(Stall);
                prev_stall = Stall;
            end
        end
        check("responded", {31'b0, ended}, 32'd1);
    endtask

    initial begin
        logic any_evt;
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
        ALUResult = '0; WriteData = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_strb", {28'b0, mem_wstrb}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", ReadData, 32'd0);
        check("rst_flags", {28'b0, Done, Misaligned, BusError, Stall}, 32'd0);
        reset = 1'b1;

        run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF7F01, 0, 4'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF7F01, 0, 4'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 32'h80FF7F01, 0, 4'b0, 32'h0);
        run_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD);
        run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'hABCD0000, 0, 4'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 4'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0, 4'b0, 32'h0);
        run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5);
        run_op(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF7F01, 0, 4'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'b010, 32'h208, 32'h0, 32'h0BADF00D, 3, 4'b0, 32'h0);
        run_op(1'b1, 1'b1, 3'b010, 32'h104, 32'hFFFFFFFF, 32'h11223344, 0, 4'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h55555555, -1, 4'b0, 32'h0);
        run_op(1'b0, 1'b1, 3'b001, 32'h500, 32'h00007E81, 32'h0, 2, 4'b0011, 32'h7E817E81);

        // Reset asserted in the second REQ cycle of a load.
        op_id++;
        @(posedge clk); #1;
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h600; mem_rdata = 32'hCAFEBABE;
        @(posedge clk); #1;
        check("mid_req", {31'b0, mem_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_req_off", {31'b0, mem_req}, 32'd0);
        check("mid_stall", {31'b0, Stall}, 32'd0);
        check("mid_rdata", ReadData, 32'd0);
        any_evt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'(i % 2);
            @(posedge clk); #1;
            any_evt |= Done | BusError | mem_req;
        end
        mem_ready = 1'b0;
        check("mid_no_evt", {31'b0, any_evt}, 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
